// File: rtl/resource_requester_pkg.sv
// Shared state encoding and default widths for the resource requester.
package resource_requester_pkg;

  localparam int ADDRESS_WIDTH_DEF  = 8;
  localparam int ID_WIDTH_DEF       = 4;
  localparam int DATA_WIDTH_DEF     = 16;
  localparam int TIMEOUT_CYCLES_DEF = 64;
  localparam int LAT_WIDTH_DEF      = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

endpackage

// File: rtl/resource_requester.sv
// Issues one tagged request at a time to a shared resource and returns its response upstream.
// Optional response timeout is enabled with the REQUESTER_TIMEOUT_EN macro.
module resource_requester
  import resource_requester_pkg::*;
#(
  parameter int ADDRESS_WIDTH  = ADDRESS_WIDTH_DEF,
  parameter int ID_WIDTH       = ID_WIDTH_DEF,
  parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int LAT_WIDTH      = LAT_WIDTH_DEF
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     req_valid,
  input  logic [ADDRESS_WIDTH-1:0] req_address,
  output logic                     req_ready,
  output logic [ADDRESS_WIDTH-1:0] res_address,
  output logic [ID_WIDTH-1:0]      res_id,
  output logic                     res_valid,
  input  logic                     res_ready,
  input  logic [DATA_WIDTH-1:0]    res_data,
  input  logic [ID_WIDTH-1:0]      res_rid,
  input  logic                     res_rvalid,
  output logic                     rsp_valid,
  output logic [DATA_WIDTH-1:0]    rsp_data,
  output logic [ID_WIDTH-1:0]      rsp_id,
  output logic                     rsp_error,
  input  logic                     rsp_ready,
  output logic [LAT_WIDTH-1:0]     last_latency,
  output logic                     id_mismatch
);

  state_t state, state_nx;
  logic [ID_WIDTH-1:0]  tag_cnt;
  logic [LAT_WIDTH-1:0] lat_cnt, lat_inc;
  logic                 rsp_hit, tag_bad, timeout;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  assign rsp_hit = (state == WAIT) && res_rvalid && (res_rid == res_id);
  assign tag_bad = (state == WAIT) && res_rvalid && (res_rid != res_id);
  assign lat_inc = (lat_cnt == '1) ? lat_cnt : lat_cnt + 1'b1;

`ifdef REQUESTER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] wait_cnt;
  logic          err_q;

  // A late hit wins over a timeout landing on the same edge.
  assign timeout   = (state == WAIT) && !rsp_hit && (wait_cnt == TW'(TIMEOUT_CYCLES - 1));
  assign rsp_error = err_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      if (res_valid)           wait_cnt <= '0;
      else if (state == WAIT)  wait_cnt <= wait_cnt + 1'b1;
      if (rsp_hit)             err_q <= 1'b0;
      else if (timeout)        err_q <= 1'b1;
    end
  end
`else
  assign timeout   = 1'b0;
  assign rsp_error = 1'b0;
`endif

  always_comb begin
    state_nx  = state;
    req_ready = 1'b0;
    res_valid = 1'b0;
    rsp_valid = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nx = ISSUE;
      end
      ISSUE: begin
        res_valid = res_ready;
        if (res_ready) state_nx = WAIT;
      end
      WAIT: begin
        if (rsp_hit || timeout) state_nx = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      tag_cnt      <= '0;
      res_address  <= '0;
      res_id       <= '0;
      lat_cnt      <= '0;
      rsp_data     <= '0;
      rsp_id       <= '0;
      last_latency <= '0;
      id_mismatch  <= 1'b0;
    end else begin
      state <= state_nx;
      // The tag is sampled on acceptance so res_id stays put while tag_cnt advances at issue.
      if (state == IDLE && req_valid) begin
        res_address <= req_address;
        res_id      <= tag_cnt;
      end
      if (res_valid) begin
        tag_cnt <= tag_cnt + 1'b1;
        lat_cnt <= '0;
      end else if (state == WAIT) begin
        lat_cnt <= lat_inc;
      end
      if (rsp_hit || timeout) begin
        rsp_data     <= rsp_hit ? res_data : '0;
        rsp_id       <= res_id;
        last_latency <= lat_inc;
      end
      if (tag_bad) id_mismatch <= 1'b1;
    end
  end

endmodule

// File: tb/tb_resource_requester.sv
// Directed bench for resource_requester with a resource model answering addr+0x200 four cycles after accept.
module tb_resource_requester;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid;
  logic [7:0]  req_address;
  logic        req_ready;
  logic [7:0]  res_address;
  logic [3:0]  res_id;
  logic        res_valid;
  logic        res_ready;
  logic [15:0] res_data;
  logic [3:0]  res_rid;
  logic        res_rvalid;
  logic        rsp_valid;
  logic [15:0] rsp_data;
  logic [3:0]  rsp_id;
  logic        rsp_error;
  logic        rsp_ready;
  logic [7:0]  last_latency;
  logic        id_mismatch;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int pulse_cnt = 0;

  resource_requester dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_address(req_address), .req_ready(req_ready),
    .res_address(res_address), .res_id(res_id), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_rid(res_rid), .res_rvalid(res_rvalid),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_id(rsp_id), .rsp_error(rsp_error),
    .rsp_ready(rsp_ready), .last_latency(last_latency), .id_mismatch(id_mismatch)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (res_valid === 1'b1) pulse_cnt++;

  task automatic apply_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  // Drives one full transaction; ok drops on any handshake or stability violation.
  task automatic run_txn(input logic [7:0] addr, input bit bad_first, input int iss_hold,
                         input int rsp_hold, output logic [3:0] id, output logic [15:0] data,
                         output logic [3:0] rid, output logic [7:0] lat, output logic err,
                         output bit ok);
    logic [15:0] snap_d;
    logic [3:0]  snap_i;
    ok = 1;
    res_ready = (iss_hold == 0);
    req_valid = 1'b1;
    req_address = addr;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_address = '0;
    for (int k = 0; k < iss_hold; k++) begin
      if (res_valid !== 1'b0 || req_ready !== 1'b0) ok = 0;
      @(posedge clk); #1;
    end
    res_ready = 1'b1;
    #1;
    if (res_valid !== 1'b1 || res_address !== addr) ok = 0;
    id = res_id;
    @(posedge clk); #1;
    if (res_valid !== 1'b0) ok = 0;
    for (int k = 1; k <= 3; k++) begin
      res_rvalid = bad_first && (k == 2);
      res_rid    = id + 4'd1;
      res_data   = 16'hDEAD;
      if (res_id !== id || res_address !== addr) ok = 0;
      @(posedge clk); #1;
    end
    res_rvalid = 1'b1;
    res_rid    = id;
    res_data   = 16'h0200 + {8'h00, addr};
    @(posedge clk); #1;
    res_rvalid = 1'b0;
    snap_d = rsp_data;
    snap_i = rsp_id;
    for (int k = 0; k < rsp_hold; k++) begin
      if (rsp_valid !== 1'b1 || rsp_data !== snap_d || rsp_id !== snap_i) ok = 0;
      @(posedge clk); #1;
    end
    data = rsp_data;
    rid  = rsp_id;
    lat  = last_latency;
    err  = rsp_error;
    if (rsp_valid !== 1'b1) ok = 0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) ok = 0;
  endtask

  task automatic start_wait(input logic [7:0] addr, output logic [3:0] id);
    res_ready = 1'b1;
    req_valid = 1'b1;
    req_address = addr;
    @(posedge clk); #1;
    req_valid = 1'b0;
    id = res_id;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    apply_reset();
    total_cnt++;
    if ({req_ready, res_valid, rsp_valid, id_mismatch, rsp_error} !== 5'b10000)
      $display("FAIL reset_flags got=%b exp=10000", {req_ready, res_valid, rsp_valid, id_mismatch, rsp_error});
    else pass_cnt++;
    total_cnt++;
    if ({res_address, res_id, rsp_data, rsp_id, last_latency} !== 40'd0)
      $display("FAIL reset_regs got=%h exp=0", {res_address, res_id, rsp_data, rsp_id, last_latency});
    else pass_cnt++;
  endtask

  task automatic test_basic();
    logic [3:0] id, rid; logic [15:0] d; logic [7:0] lat; logic err; bit ok; int p0;
    p0 = pulse_cnt;
    run_txn(8'h05, 0, 0, 0, id, d, rid, lat, err, ok);
    total_cnt++;
    if (!ok) $display("FAIL basic_handshake got=0 exp=1"); else pass_cnt++;
    total_cnt++;
    if (pulse_cnt - p0 !== 1) $display("FAIL basic_pulses got=%0d exp=1", pulse_cnt - p0); else pass_cnt++;
    total_cnt++;
    if (id !== 4'd0 || rid !== 4'd0) $display("FAIL basic_id got=%0d/%0d exp=0/0", id, rid); else pass_cnt++;
    total_cnt++;
    if (d !== 16'h0205) $display("FAIL basic_data got=%h exp=0205", d); else pass_cnt++;
    total_cnt++;
    if (lat !== 8'd4) $display("FAIL basic_latency got=%0d exp=4", lat); else pass_cnt++;
    total_cnt++;
    if (err !== 1'b0 || id_mismatch !== 1'b0)
      $display("FAIL basic_err_mismatch got=%b%b exp=00", err, id_mismatch);
    else pass_cnt++;
  endtask

  task automatic test_issue_backpressure();
    logic [3:0] id, rid; logic [15:0] d; logic [7:0] lat; logic err; bit ok; int p0;
    p0 = pulse_cnt;
    run_txn(8'h3C, 0, 10, 0, id, d, rid, lat, err, ok);
    total_cnt++;
    if (!ok) $display("FAIL issue_hold got=0 exp=1"); else pass_cnt++;
    total_cnt++;
    if (pulse_cnt - p0 !== 1) $display("FAIL issue_hold_pulses got=%0d exp=1", pulse_cnt - p0); else pass_cnt++;
    total_cnt++;
    if (id !== 4'd1 || d !== 16'h023C) $display("FAIL issue_hold_resp got=%0d/%h exp=1/023c", id, d);
    else pass_cnt++;
  endtask

  task automatic test_tag_wrap();
    logic [3:0] id, rid; logic [15:0] d; logic [7:0] lat; logic err; bit ok;
    logic [15:0] seen;
    logic [7:0]  a;
    apply_reset();
    seen = '0;
    for (int i = 0; i < 17; i++) begin
      a = 8'h10 + 8'(i);
      run_txn(a, 0, 0, 0, id, d, rid, lat, err, ok);
      if (i < 16) seen[id] = 1'b1;
      total_cnt++;
      if (!ok || id !== 4'(i) || rid !== 4'(i) || d !== (16'h0200 + {8'h00, a}))
        $display("FAIL wrap_txn%0d got=ok%0d id%0d data%h exp=ok1 id%0d data%h",
                 i, ok, id, d, i % 16, 16'h0200 + {8'h00, a});
      else pass_cnt++;
    end
    total_cnt++;
    if (seen !== 16'hFFFF) $display("FAIL wrap_unique got=%h exp=ffff", seen); else pass_cnt++;
    total_cnt++;
    if (id !== 4'd0) $display("FAIL wrap_17th_id got=%0d exp=0", id); else pass_cnt++;
  endtask

  task automatic test_id_mismatch();
    logic [3:0] id, rid; logic [15:0] d; logic [7:0] lat; logic err; bit ok;
    total_cnt++;
    if (id_mismatch !== 1'b0) $display("FAIL mismatch_pre got=%b exp=0", id_mismatch); else pass_cnt++;
    run_txn(8'hA7, 1, 0, 0, id, d, rid, lat, err, ok);
    total_cnt++;
    if (id_mismatch !== 1'b1) $display("FAIL mismatch_sticky got=%b exp=1", id_mismatch); else pass_cnt++;
    total_cnt++;
    if (!ok || d !== 16'h02A7 || rid !== id || lat !== 8'd4)
      $display("FAIL mismatch_resp got=ok%0d data%h lat%0d exp=ok1 data02a7 lat4", ok, d, lat);
    else pass_cnt++;
  endtask

  task automatic test_rsp_hold();
    logic [3:0] id, rid; logic [15:0] d; logic [7:0] lat; logic err; bit ok;
    run_txn(8'h42, 0, 0, 5, id, d, rid, lat, err, ok);
    total_cnt++;
    if (!ok) $display("FAIL rsp_hold_stable got=0 exp=1"); else pass_cnt++;
    total_cnt++;
    if (d !== 16'h0242 || rid !== id) $display("FAIL rsp_hold_data got=%h exp=0242", d); else pass_cnt++;
  endtask

  task automatic test_timeout_and_reset();
    logic [3:0] id;
    int n;
    bit seen_rsp;
    start_wait(8'h99, id);
`ifdef REQUESTER_TIMEOUT_EN
    n = 0;
    while (rsp_valid !== 1'b1 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    total_cnt++;
    if (n !== 64) $display("FAIL timeout_cycles got=%0d exp=64", n); else pass_cnt++;
    total_cnt++;
    if (rsp_valid !== 1'b1 || rsp_error !== 1'b1 || rsp_data !== 16'h0000 || rsp_id !== id)
      $display("FAIL timeout_resp got=v%b e%b d%h exp=v1 e1 d0000", rsp_valid, rsp_error, rsp_data);
    else pass_cnt++;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    start_wait(8'h9A, id);
`else
    seen_rsp = 0;
    for (int k = 0; k < 100; k++) begin
      if (rsp_valid !== 1'b0 || req_ready !== 1'b0) seen_rsp = 1;
      @(posedge clk); #1;
    end
    total_cnt++;
    if (seen_rsp) $display("FAIL unbounded_wait got=left_wait exp=still_waiting"); else pass_cnt++;
    total_cnt++;
    if (rsp_error !== 1'b0) $display("FAIL error_tied got=%b exp=0", rsp_error); else pass_cnt++;
`endif
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b0;
    #2;
    total_cnt++;
    if ({req_ready, res_valid, rsp_valid, id_mismatch, rsp_error} !== 5'b10000 ||
        {res_address, res_id, rsp_data, rsp_id, last_latency} !== 40'd0)
      $display("FAIL midwait_reset got=%b_%h exp=10000_0",
               {req_ready, res_valid, rsp_valid, id_mismatch, rsp_error},
               {res_address, res_id, rsp_data, rsp_id, last_latency});
    else pass_cnt++;
    reset_n = 1'b1;
    @(posedge clk); #1;
    res_rvalid = 1'b1;
    res_rid    = id;
    res_data   = 16'hBEEF;
    @(posedge clk); #1;
    res_rvalid = 1'b0;
    total_cnt++;
    if (rsp_valid !== 1'b0 || id_mismatch !== 1'b0 || req_ready !== 1'b1)
      $display("FAIL late_resp_ignored got=v%b m%b r%b exp=v0 m0 r1", rsp_valid, id_mismatch, req_ready);
    else pass_cnt++;
    start_wait(8'h01, id);
    total_cnt++;
    if (id !== 4'd0) $display("FAIL tag_after_reset got=%0d exp=0", id); else pass_cnt++;
    apply_reset();
  endtask

  initial begin
    reset_n     = 1'b0;
    req_valid   = 1'b0;
    req_address = '0;
    res_ready   = 1'b1;
    res_data    = '0;
    res_rid     = '0;
    res_rvalid  = 1'b0;
    rsp_ready   = 1'b0;
    test_reset();
    test_basic();
    test_issue_backpressure();
    test_tag_wrap();
    test_id_mismatch();
    test_rsp_hold();
    test_timeout_and_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/resource_requester.md
RESOURCE_REQUESTER -- requirements
Module: resource_requester

Interface
REQ-001 Parameter ADDRESS_WIDTH, default 8, width of the request address.
REQ-002 Parameter ID_WIDTH, default 4, width of the transaction tag.
REQ-003 Parameter DATA_WIDTH, default 16, width of the response data.
REQ-004 Parameter TIMEOUT_CYCLES, default 64, maximum wait for a response.
REQ-005 Parameter LAT_WIDTH, default 8, width of the latency measurement.
REQ-006 Ports SHALL be, one per line:
- clk  in  1  single clock; all state on its rising edge.
- reset_n  in  1  reset, asynchronous, active-low.
- req_valid  in  1  upstream request present.
- req_address  in  ADDRESS_WIDTH  upstream request address.
- req_ready  out  1  requester accepts an upstream request.
- res_address  out  ADDRESS_WIDTH  address driven to the shared resource.
- res_id  out  ID_WIDTH  tag driven to the shared resource.
- res_valid  out  1  single-cycle request strobe to the shared resource.
- res_ready  in  1  shared resource idle.
- res_data  in  DATA_WIDTH  resource response data.
- res_rid  in  ID_WIDTH  resource response tag.
- res_rvalid  in  1  resource response strobe.
- rsp_valid  out  1  upstream response present.
- rsp_data  out  DATA_WIDTH  upstream response data.
- rsp_id  out  ID_WIDTH  tag of the returned transaction.
- rsp_error  out  1  response produced by timeout.
- rsp_ready  in  1  upstream accepts the response.
- last_latency  out  LAT_WIDTH  cycles from issue to response of the last transaction.
- id_mismatch  out  1  sticky: response strobe seen with a wrong tag.

Function
REQ-007 FSM states SHALL be IDLE, ISSUE, WAIT and RESP.
REQ-008 IDLE: req_ready=1; on req_valid, latch req_address and go to ISSUE.
REQ-009 req_ready SHALL be 0 in every state other than IDLE.
REQ-010 ISSUE: res_valid=(state==ISSUE)&&res_ready, combinational; on res_ready=1, go to WAIT at that edge.
REQ-011 res_valid SHALL be high for exactly one cycle per transaction.
REQ-012 res_address and res_id SHALL stay stable from ISSUE entry until WAIT exit.
REQ-013 Tag counter SHALL increment by 1 on each issue and wrap from 2^ID_WIDTH-1 to 0.
REQ-014 WAIT: res_rvalid with res_rid==res_id SHALL capture res_data into rsp_data and go to RESP, rsp_error=0.
REQ-015 WAIT: res_rvalid with res_rid!=res_id SHALL set id_mismatch and be otherwise ignored.
REQ-016 Latency counter SHALL clear on issue, increment each WAIT cycle, and saturate at 2^LAT_WIDTH-1.
REQ-017 The latency count SHALL load into last_latency when RESP is entered.
REQ-018 RESP: rsp_valid=1 with rsp_data, rsp_id and rsp_error held stable until rsp_ready=1; on rsp_ready go to IDLE.
REQ-019 res_rvalid outside WAIT SHALL be ignored; it SHALL NOT set id_mismatch.

Reset
REQ-020 reset_n=0 SHALL asynchronously force IDLE.
REQ-021 Reset SHALL clear the tag counter, res_address, rsp_data, rsp_id, rsp_error, last_latency and id_mismatch to 0.
REQ-022 After reset, res_valid=0, rsp_valid=0 and req_ready=1.
REQ-023 Reset in WAIT SHALL abandon the transaction; a late response SHALL be ignored.

Configuration
REQ-024 With REQUESTER_TIMEOUT_EN defined: WAIT lasting TIMEOUT_CYCLES cycles SHALL enter RESP with rsp_data=0 and rsp_error=1.
REQ-025 Without REQUESTER_TIMEOUT_EN: WAIT SHALL be unbounded, and rsp_error SHALL be tied to 0.

Structure
REQ-026 A shared package SHALL hold the state encoding and the default widths.
REQ-027 The design SHALL be a single module with no sub-modules.

Verification
REQ-028 Bench resource model returns address+0x200 four cycles after accept. Address 0x05 -> one res_valid pulse with res_id=0; rsp_data=0x0205, rsp_id=0, last_latency=4.
REQ-029 Hold res_ready=0 for 10 cycles during ISSUE -> no res_valid pulse, req_ready=0; issue occurs on the first cycle res_ready=1.
REQ-030 Run 17 back-to-back transactions with ID_WIDTH=4 -> the 17th transaction uses res_id=0, and no tag repeats within 16 transactions.
REQ-031 Model answers with res_rid=res_id+1, then the correct tag -> id_mismatch=1 and the correct data is returned.
REQ-032 With the macro defined, the model never answers -> after 64 WAIT cycles, rsp_valid=1, rsp_error=1, rsp_data=0; without the macro, it waits indefinitely.
REQ-033 Hold rsp_ready=0 for 5 cycles, then pulse reset_n low mid-WAIT -> the response stays stable until accepted; after reset, IDLE with all outputs at their reset values.
